// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: NOP encoding, read-owner tag and the
// byte-to-word address helper used by the instruction memory arbiter.
package riscv_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          MADDR_W = 15;

  typedef enum logic {OWN_FETCH = 1'b0, OWN_LOAD = 1'b1} own_e;

  function automatic logic [MADDR_W-1:0] word_addr(input logic [31:0] a);
    return a[MADDR_W+1:2];
  endfunction

endpackage

// File: rtl/prio_burst_arb.sv
// Loader-first arbiter; fetch is forced through after MAX_BURST consecutive
// loader grants while it has been waiting.
module prio_burst_arb #(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_f_req,
  input  logic i_l_req,
  output logic o_f_gnt,
  output logic o_l_gnt
);

  logic [3:0] r_burst;
  logic       w_force_f;

  assign w_force_f = i_f_req && (r_burst == 4'(MAX_BURST));
  assign o_l_gnt   = !rst && i_l_req && !w_force_f;
  assign o_f_gnt   = !rst && i_f_req && !o_l_gnt;

  // Counter only grows while fetch waits, so it tops out at MAX_BURST.
  always_ff @(posedge clk) begin
    if (rst || !i_f_req || o_f_gnt) r_burst <= 4'd0;
    else if (o_l_gnt)               r_burst <= r_burst + 4'd1;
  end

endmodule

// File: rtl/imem_arb.sv
// Instruction memory arbiter: shares one single-port SRAM between the fetch
// front end and the loader/debug port, with fixed one-cycle read return.
module imem_arb
  import riscv_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [14:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        fetch_stall
);

  own_e r_own;
  logic r_rvld;
  logic w_rd_gnt;
  logic w_unused_bits;

  prio_burst_arb #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_f_req (f_req),
    .i_l_req (l_req),
    .o_f_gnt (f_gnt),
    .o_l_gnt (l_gnt)
  );

  assign w_rd_gnt    = f_gnt | (l_gnt & ~l_we);
  assign fetch_stall = f_req & ~f_gnt;

  assign m_en    = f_gnt | l_gnt;
  assign m_we    = l_gnt & l_we;
  assign m_addr  = l_gnt ? word_addr(l_addr) : (f_gnt ? word_addr(f_addr) : '0);
  assign m_wdata = m_we ? l_wdata : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvld <= 1'b0;
      r_own  <= OWN_FETCH;
    end else begin
      r_rvld <= w_rd_gnt;
      if (w_rd_gnt) r_own <= l_gnt ? OWN_LOAD : OWN_FETCH;
    end
  end

  // rst masks the return combinationally so a read granted just before reset
  // never shows up, even in the reset cycle itself.
  assign f_rvalid = r_rvld & ~rst & (r_own == OWN_FETCH);
  assign l_rvalid = r_rvld & ~rst & (r_own == OWN_LOAD);
  assign f_rdata  = f_rvalid ? m_rdata : NOP;
  assign l_rdata  = l_rvalid ? m_rdata : 32'd0;

  assign w_unused_bits = ^{f_addr[31:17], f_addr[1:0], l_addr[31:17], l_addr[1:0]};

endmodule

// File: tb/tb_imem_arb.sv
// Directed bench for imem_arb with a behavioural SRAM and a per-cycle
// scoreboard of expected read returns.
module tb_imem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, l_req, l_we;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, l_gnt, l_rvalid;
  logic [31:0] f_rdata, l_rdata;
  logic        m_en, m_we;
  logic [14:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic        fetch_stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        fv;
    logic        lv;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] mem [0:32767];
  logic [31:0] ref_w [int];

  always #5 clk = ~clk;

  imem_arb #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .fetch_stall(fetch_stall)
  );

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  function automatic logic [31:0] init_word(input int wa);
    return 32'hA500_0000 + 32'(wa);
  endfunction

  function automatic logic [31:0] ref_rd(input int wa);
    if (ref_w.exists(wa)) return ref_w[wa];
    return init_word(wa);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic fr, input logic [31:0] fa,
                      input logic lr, input logic lw, input logic [31:0] la,
                      input logic [31:0] ld, input logic efg, input logic elg,
                      input string tag);
    exp_t e, n;
    int   wa;
    logic [14:0] ema;
    @(negedge clk);
    rst = r; f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
    #1;
    e = exp_q.pop_front();
    if (r) begin
      e.fv = 1'b0; e.lv = 1'b0;
    end
    chk({tag, ".f_rvalid"}, 32'(f_rvalid), 32'(e.fv));
    chk({tag, ".l_rvalid"}, 32'(l_rvalid), 32'(e.lv));
    chk({tag, ".f_rdata"},  f_rdata, e.fv ? e.data : 32'h0000_0013);
    chk({tag, ".l_rdata"},  l_rdata, e.lv ? e.data : 32'd0);
    chk({tag, ".f_gnt"},    32'(f_gnt), 32'(efg));
    chk({tag, ".l_gnt"},    32'(l_gnt), 32'(elg));
    chk({tag, ".stall"},    32'(fetch_stall), 32'(fr & ~efg));
    chk({tag, ".m_en"},     32'(m_en), 32'(efg | elg));
    chk({tag, ".m_we"},     32'(m_we), 32'(elg & lw));
    ema = elg ? la[16:2] : (efg ? fa[16:2] : 15'd0);
    chk({tag, ".m_addr"},   32'(m_addr), 32'(ema));
    chk({tag, ".m_wdata"},  m_wdata, (elg & lw) ? ld : 32'd0);
    wa     = int'(ema);
    n.fv   = efg;
    n.lv   = elg & ~lw;
    n.data = ref_rd(wa);
    if (elg & lw) ref_w[wa] = ld;
    exp_q.push_back(n);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = init_word(i);
    m_rdata = 32'd0;
    rst = 1'b1; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
    f_addr = '0; l_addr = '0; l_wdata = '0;
    exp_q.push_back('{fv: 1'b0, lv: 1'b0, data: 32'd0});

    // Reset with both requesters active: nothing granted.
    step(1, 1, 32'h0, 1, 0, 32'h4, 0, 0, 0, "rst0");
    step(1, 1, 32'h4, 1, 1, 32'h8, 32'h1, 0, 0, "rst1");

    // Fetch only, consecutive words.
    step(0, 1, 32'h0, 0, 0, 0, 0, 1, 0, "fo0");
    step(0, 1, 32'h4, 0, 0, 0, 0, 1, 0, "fo1");
    step(0, 1, 32'h8, 0, 0, 0, 0, 1, 0, "fo2");
    step(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, "fo_idle");

    // Contention: four loader writes, one forced fetch, then loader again.
    for (int i = 0; i < 4; i++)
      step(0, 1, 32'h40, 1, 1, 32'h200, 32'h1000 + 32'(i), 0, 1, $sformatf("ct_l%0d", i));
    step(0, 1, 32'h40, 1, 1, 32'h200, 32'h2000, 1, 0, "ct_f");
    step(0, 1, 32'h40, 1, 1, 32'h200, 32'h3000, 0, 1, "ct_l5");
    step(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, "ct_idle");

    // Loader write then fetch read of the same word.
    step(0, 0, 32'h0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 1, "raw_w");
    step(0, 1, 32'h100, 0, 0, 0, 0, 1, 0, "raw_r");
    step(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, "raw_idle");

    // Loader read.
    step(0, 0, 32'h0, 1, 0, 32'h8, 0, 0, 1, "lr");
    step(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, "lr_idle");

    // Reset in the cycle after a fetch grant drops the read.
    step(0, 1, 32'h0, 0, 0, 0, 0, 1, 0, "rm_f");
    step(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, "rm_rst");
    step(0, 1, 32'h0, 0, 0, 0, 0, 1, 0, "rm_fo0");
    step(0, 1, 32'h4, 0, 0, 0, 0, 1, 0, "rm_fo1");
    step(0, 1, 32'h8, 0, 0, 0, 0, 1, 0, "rm_fo2");

    // High address bits alias onto the word address.
    step(0, 1, 32'h0002_0004, 0, 0, 0, 0, 1, 0, "alias");
    step(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
